// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one memory port between the instruction-fetch unit (f_*) and the
//   load/store unit (d_*). One transaction is in flight at a time. Simultaneous
//   requests alternate round-robin. Misaligned or illegal-size accesses are
//   rejected without touching memory. A Busy watchdog aborts a transaction
//   that never receives mem_ack.
//
// Ports
//   __clk, __rst_n      clock, async active-low reset
//   f_req/f_addr        fetch request (word read only)
//   f_done/f_err        one-cycle completion / error pulses, f_rdata read data
//   d_req/d_addr/d_wdata/d_we/d_size   data request
//   d_done/d_err        one-cycle completion / error pulses, d_rdata load data
//   mem_req/mem_addr/mem_wdata/mem_we/mem_size   memory request (level)
//   mem_ack/mem_rdata   memory completion and read data
//   busy                any state other than StIdle
//   owner               last or current grant, 0 = data, 1 = fetch
//
// state  | meaning
// StIdle | waiting for a request, arbitration happens here
// StBusy | grant latched; memory access running, or a rejected access
//        | spending its single Busy cycle with mem_req low
// StDone | done/err pulse visible for this cycle, requests ignored
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              __clk,
    input  logic              __rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic              f_err,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    output logic              d_done,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    // Down-counter width; at least one bit so TIMEOUT of 0 or 1 still elaborates.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t            state;
    logic              cur_f;      // current grantee is fetch
    logic              reject;     // latched access failed the alignment check
    logic [TW-1:0]     tmo_cnt;

    logic              gnt_f;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic [1:0]        sel_size;
    logic              sel_bad;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        gnt_f = f_req;
        if (f_req && d_req) begin
            gnt_f = ~owner;
        end
    end

    always_comb begin
        sel_addr  = gnt_f ? f_addr : d_addr;
        sel_wdata = gnt_f ? '0 : d_wdata;
        sel_we    = gnt_f ? 1'b0 : d_we;
        sel_size  = gnt_f ? 2'd2 : d_size;
        sel_bad   = 1'b0;
        case (sel_size)
            2'd1:    sel_bad = sel_addr[0];
            2'd2:    sel_bad = (sel_addr[1:0] != 2'b00);
            2'd3:    sel_bad = 1'b1;
            default: sel_bad = 1'b0;
        endcase
    end

    assign busy = (state != StIdle);

    always_ff @(posedge __clk or negedge __rst_n) begin
        if (!__rst_n) begin
            state     <= StIdle;
            cur_f     <= 1'b0;
            reject    <= 1'b0;
            tmo_cnt   <= '0;
            owner     <= 1'b0;
            f_done    <= 1'b0;
            f_err     <= 1'b0;
            f_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_size  <= 2'd0;
        end else begin
            f_done <= 1'b0;
            f_err  <= 1'b0;
            d_done <= 1'b0;
            d_err  <= 1'b0;
            case (state)
                StIdle: begin
                    if (f_req || d_req) begin
                        owner     <= gnt_f;
                        cur_f     <= gnt_f;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_we    <= sel_we;
                        mem_size  <= sel_size;
                        reject    <= sel_bad;
                        mem_req   <= ~sel_bad;
                        tmo_cnt   <= TW'(TIMEOUT);
                        state     <= StBusy;
                    end
                end
                StBusy: begin
                    if (reject) begin
                        // mem_req never rose, so any mem_ack here is stray.
                        reject <= 1'b0;
                        f_err  <= cur_f;
                        d_err  <= ~cur_f;
                        state  <= StDone;
                    end else if (mem_ack) begin
                        // Ack beats a coincident timeout expiry.
                        mem_req <= 1'b0;
                        if (!mem_we) begin
                            if (cur_f) f_rdata <= mem_rdata;
                            else       d_rdata <= mem_rdata;
                        end
                        f_done <= cur_f;
                        d_done <= ~cur_f;
                        state  <= StDone;
                    end else if ((TIMEOUT != 0) && (tmo_cnt == TW'(1))) begin
                        mem_req <= 1'b0;
                        f_err   <= cur_f;
                        d_err   <= ~cur_f;
                        state   <= StDone;
                    end else if (tmo_cnt != '0) begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        f_req;
    logic [31:0] f_addr;
    logic        f_done;
    logic        f_err;
    logic [31:0] f_rdata;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_we;
    logic [1:0]  d_size;
    logic        d_done;
    logic        d_err;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        owner;

    int n_vec;
    int n_err;
    logic [31:0] exp_d_rdata;
    logic [31:0] exp_f_rdata;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .__clk(clk), .__rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_err(f_err), .f_rdata(f_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_wdata(d_wdata), .d_we(d_we), .d_size(d_size),
        .d_done(d_done), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; f_req = 0; f_addr = 0; d_req = 0; d_addr = 0; d_wdata = 0;
        d_we = 0; d_size = 0; mem_ack = 0; mem_rdata = 0;
        #2;
        n_vec++; if ({f_done, f_err, d_done, d_err, mem_req, mem_we, busy, owner} !== 8'h00) begin n_err++; $display("FAIL reset_flags got=%b exp=00000000", {f_done, f_err, d_done, d_err, mem_req, mem_we, busy, owner}); end
        n_vec++; if ({f_rdata, d_rdata, mem_addr, mem_wdata, mem_size} !== 130'd0) begin n_err++; $display("FAIL reset_data got nonzero f_rdata=%h d_rdata=%h mem_addr=%h", f_rdata, d_rdata, mem_addr); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy got=%b exp=0", busy); end
    endtask

    task automatic test_tie();
        f_req = 1; d_req = 1; f_addr = 32'h200; d_addr = 32'h300; d_we = 0; d_size = 2; mem_ack = 0;
        tick();
        n_vec++; if (owner !== 1'b1) begin n_err++; $display("FAIL tie1_owner got=%b exp=1", owner); end
        n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h200}) begin n_err++; $display("FAIL tie1_mem got req=%b addr=%h exp req=1 addr=200", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        tick();
        n_vec++; if ({f_done, f_err, d_done, d_err} !== 4'b1000) begin n_err++; $display("FAIL tie1_pulse got=%b exp=1000", {f_done, f_err, d_done, d_err}); end
        n_vec++; if (f_rdata !== 32'h1111_1111) begin n_err++; $display("FAIL tie1_rdata got=%h exp=11111111", f_rdata); end
        mem_ack = 0; f_addr = 32'h204;
        tick();
        n_vec++; if ({busy, f_done} !== 2'b00) begin n_err++; $display("FAIL tie_gap got busy,f_done=%b exp=00", {busy, f_done}); end
        tick();
        n_vec++; if ({owner, mem_req, mem_addr} !== {1'b0, 1'b1, 32'h300}) begin n_err++; $display("FAIL tie2_grant got owner=%b req=%b addr=%h exp 0 1 300", owner, mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h2222_2222;
        tick();
        n_vec++; if ({f_done, f_err, d_done, d_err} !== 4'b0010) begin n_err++; $display("FAIL tie2_pulse got=%b exp=0010", {f_done, f_err, d_done, d_err}); end
        n_vec++; if ({d_rdata, f_rdata} !== {32'h2222_2222, 32'h1111_1111}) begin n_err++; $display("FAIL tie2_rdata got d=%h f=%h exp d=22222222 f=11111111", d_rdata, f_rdata); end
        mem_ack = 0; d_addr = 32'h304;
        tick();
        tick();
        n_vec++; if ({owner, mem_addr} !== {1'b1, 32'h204}) begin n_err++; $display("FAIL tie3_grant got owner=%b addr=%h exp 1 204", owner, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h3333_3333;
        tick();
        n_vec++; if ({f_done, d_done, f_rdata} !== {2'b10, 32'h3333_3333}) begin n_err++; $display("FAIL tie3_done got f_done=%b d_done=%b f_rdata=%h exp 1 0 33333333", f_done, d_done, f_rdata); end
        f_req = 0; d_req = 0; mem_ack = 0;
        tick(); tick();
        exp_d_rdata = 32'h2222_2222;
    endtask

    task automatic test_fetch_only();
        f_req = 1; f_addr = 32'h100; mem_ack = 0;
        tick();
        n_vec++; if ({mem_req, mem_we, mem_size, busy, owner} !== 6'b101011) begin n_err++; $display("FAIL fetch_ctl got req,we,size,busy,owner=%b exp=101011", {mem_req, mem_we, mem_size, busy, owner}); end
        n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL fetch_addr got=%h exp=100", mem_addr); end
        tick();
        n_vec++; if ({mem_req, f_done} !== 2'b10) begin n_err++; $display("FAIL fetch_wait got req,done=%b exp=10", {mem_req, f_done}); end
        mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
        tick();
        n_vec++; if ({f_done, f_err, mem_req, busy} !== 4'b1001) begin n_err++; $display("FAIL fetch_done got done,err,req,busy=%b exp=1001", {f_done, f_err, mem_req, busy}); end
        n_vec++; if (f_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL fetch_rdata got=%h exp=deadbeef", f_rdata); end
        f_req = 0; mem_ack = 0;
        tick();
        n_vec++; if ({f_done, busy} !== 2'b00) begin n_err++; $display("FAIL fetch_end got done,busy=%b exp=00", {f_done, busy}); end
        exp_f_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_size = 0; d_addr = 32'h203; d_wdata = 32'h55; mem_ack = 0;
        tick();
        n_vec++; if ({mem_req, mem_we, mem_size, owner} !== 5'b11000) begin n_err++; $display("FAIL store_ctl got req,we,size,owner=%b exp=11000", {mem_req, mem_we, mem_size, owner}); end
        n_vec++; if ({mem_addr, mem_wdata} !== {32'h203, 32'h55}) begin n_err++; $display("FAIL store_bus got addr=%h wdata=%h exp 203 55", mem_addr, mem_wdata); end
        mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
        tick();
        n_vec++; if ({f_done, f_err, d_done, d_err} !== 4'b0010) begin n_err++; $display("FAIL store_pulse got=%b exp=0010", {f_done, f_err, d_done, d_err}); end
        n_vec++; if (d_rdata !== exp_d_rdata) begin n_err++; $display("FAIL store_rdata_hold got=%h exp=%h", d_rdata, exp_d_rdata); end
        d_req = 0; d_we = 0; mem_ack = 0;
        tick(); tick();
    endtask

    typedef struct {
        logic        is_f;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        good;
    } align_vec_t;

    task automatic test_reject();
        align_vec_t v [6];
        logic [3:0] exp_p;
        v[0] = '{1'b0, 32'h102, 2'd2, 1'b0};
        v[1] = '{1'b0, 32'h101, 2'd1, 1'b0};
        v[2] = '{1'b0, 32'h100, 2'd3, 1'b0};
        v[3] = '{1'b0, 32'h102, 2'd1, 1'b1};
        v[4] = '{1'b0, 32'h104, 2'd2, 1'b1};
        v[5] = '{1'b1, 32'h106, 2'd2, 1'b0};
        for (int i = 0; i < 6; i++) begin
            f_req = v[i].is_f; d_req = ~v[i].is_f;
            f_addr = v[i].addr; d_addr = v[i].addr; d_size = v[i].size; d_we = 0;
            // Ack held high throughout: stray acks must not complete a rejected access.
            mem_ack = 1; mem_rdata = 32'hA000_0000 + i;
            tick();
            n_vec++; if ({busy, mem_req} !== {1'b1, v[i].good}) begin n_err++; $display("FAIL align%0d_busy1 got busy,req=%b exp=1%b", i, {busy, mem_req}, v[i].good); end
            tick();
            exp_p = v[i].is_f ? {v[i].good, ~v[i].good, 2'b00} : {2'b00, v[i].good, ~v[i].good};
            n_vec++; if ({f_done, f_err, d_done, d_err} !== exp_p) begin n_err++; $display("FAIL align%0d_pulse got=%b exp=%b", i, {f_done, f_err, d_done, d_err}, exp_p); end
            if (v[i].good && !v[i].is_f) exp_d_rdata = 32'hA000_0000 + i;
            n_vec++; if ({busy, mem_req, d_rdata, f_rdata} !== {2'b10, exp_d_rdata, exp_f_rdata}) begin n_err++; $display("FAIL align%0d_busy2 got busy=%b req=%b d_rdata=%h f_rdata=%h", i, busy, mem_req, d_rdata, f_rdata); end
            f_req = 0; d_req = 0; mem_ack = 0;
            tick();
            n_vec++; if ({busy, f_err, d_err} !== 3'b000) begin n_err++; $display("FAIL align%0d_end got busy,f_err,d_err=%b exp=000", i, {busy, f_err, d_err}); end
        end
    endtask

    task automatic test_timeout();
        d_req = 1; d_we = 0; d_size = 2; d_addr = 32'h400; mem_ack = 0;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if ({mem_req, d_err, d_done} !== 3'b100) begin n_err++; $display("FAIL tmo_wait%0d got req,err,done=%b exp=100", k, {mem_req, d_err, d_done}); end
            tick();
        end
        n_vec++; if ({mem_req, d_err, d_done, busy} !== 4'b0101) begin n_err++; $display("FAIL tmo_expire got req,err,done,busy=%b exp=0101", {mem_req, d_err, d_done, busy}); end
        d_req = 0;
        tick();
        n_vec++; if ({busy, d_err} !== 2'b00) begin n_err++; $display("FAIL tmo_idle got busy,err=%b exp=00", {busy, d_err}); end
        d_req = 1; d_addr = 32'h408;
        tick();
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL tmo_ack_wait%0d got req=%b exp=1", k, mem_req); end
            if (k == 3) begin mem_ack = 1; mem_rdata = 32'h4444_4444; end
            tick();
        end
        n_vec++; if ({mem_req, d_err, d_done, d_rdata} !== {3'b001, 32'h4444_4444}) begin n_err++; $display("FAIL tmo_ack_wins got req=%b err=%b done=%b rdata=%h", mem_req, d_err, d_done, d_rdata); end
        d_req = 0; mem_ack = 0;
        tick(); tick();
    endtask

    task automatic test_reset_mid_busy();
        f_req = 1; f_addr = 32'h500; mem_ack = 0;
        tick();
        n_vec++; if ({mem_req, owner} !== 2'b11) begin n_err++; $display("FAIL rstmid_pre got req,owner=%b exp=11", {mem_req, owner}); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({mem_req, busy, owner, f_done, f_err} !== 5'b00000) begin n_err++; $display("FAIL rstmid_async got req,busy,owner,done,err=%b exp=00000", {mem_req, busy, owner, f_done, f_err}); end
        f_req = 0;
        tick();
        rst_n = 1'b1;
        tick();
        n_vec++; if ({f_done, f_err, busy} !== 3'b000) begin n_err++; $display("FAIL rstmid_nopulse got done,err,busy=%b exp=000", {f_done, f_err, busy}); end
        f_req = 1; f_addr = 32'h508;
        tick();
        n_vec++; if ({mem_req, mem_addr} !== {1'b1, 32'h508}) begin n_err++; $display("FAIL rstmid_fresh got req=%b addr=%h exp 1 508", mem_req, mem_addr); end
        mem_ack = 1; mem_rdata = 32'h5555_5555;
        tick();
        n_vec++; if ({f_done, f_err, f_rdata} !== {2'b10, 32'h5555_5555}) begin n_err++; $display("FAIL rstmid_done got done=%b err=%b rdata=%h", f_done, f_err, f_rdata); end
        f_req = 0; mem_ack = 0;
        tick();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_d_rdata = 32'h0;
        exp_f_rdata = 32'h0;
        test_reset();
        test_tie();
        test_fetch_only();
        test_store();
        test_reject();
        test_timeout();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
